digit_argmax: RTL
=================

# digit_argmax

Output-side consumer of the inference sequencer. It captures the ten layer-2 class scores as the sequencer streams them out on `valid_digit`, keeping a running maximum. When the sequencer raises `check_max`, it reports the winning digit over a valid/ready result handshake. It sits between the layer-2 MAC outputs and the board display/UART logic, and it closes the loop the sequencer opens.

## Interface
Parameters:
- `SCORE_W`, 24: width of a signed two's-complement class score.
- `NUM_CLASSES`, 10: number of output classes; score indices 0..NUM_CLASSES-1 are legal.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `valid_digit`, in, 1: a score is present on `score`/`score_idx` this cycle.
- `score_idx`, in, 4: class index of the presented score; driven from the sequencer's delayed layer-1 address.
- `score`, in, SCORE_W: signed class score.
- `check_max`, in, 1: level signal that may stay high indefinitely; only its rising edge is meaningful.
- `result_ready`, in, 1: downstream accepts the result.
- `result_valid`, out, 1: `digit`, `max_score` and `count_err` are valid.
- `digit`, out, 4: index of the maximum score.
- `max_score`, out, SCORE_W: value of the maximum score.
- `count_err`, out, 1: the frame was malformed (see Operation).
- `busy`, out, 1: high while in EVAL or RESULT.

## Operation
- States:
  - COLLECT (reset state).
  - EVAL.
  - RESULT.
- Internal registers:
  - `run_max` (SCORE_W, signed), `run_idx` (4).
  - `seen` (NUM_CLASSES-bit mask), `any_seen` (1).
  - `bad` (1): sticky error.
  - `chk_q` (1): registered `check_max`.
- Behaviour in COLLECT, on `valid_digit`:
  - If `score_idx >= NUM_CLASSES`, set `bad`. The score is discarded.
  - Else if `seen[score_idx]` is already set (duplicate index), set `bad`. The score is discarded.
  - Else set `seen[score_idx]`. If `!any_seen`, or `score > run_max` (signed, strict), load `run_max <= score` and `run_idx <= score_idx`. Set `any_seen`.
- Ties: the first-arriving score wins, because the comparison is strict. With the ascending-index stream this means the lowest index wins.
- `check_max` rising edge: `check_max & !chk_q` while in COLLECT moves the FSM to EVAL.
  - A `valid_digit` in the same cycle is still accepted and included in the result.
- EVAL, one cycle:
  - `digit <= run_idx`, `max_score <= run_max`.
  - `count_err <= bad | (seen != all-ones)`.
  - Go to RESULT.
- RESULT: hold `result_valid = 1` and all outputs stable until `result_ready` is sampled high.
  - On acceptance, clear `run_max`, `run_idx`, `seen`, `any_seen` and `bad`, then return to COLLECT.
  - `digit`, `max_score` and `count_err` keep their last values.
- `valid_digit` in EVAL or RESULT is ignored and does not corrupt the held result.
- A `check_max` rising edge outside COLLECT is ignored.
- A `check_max` that stays high never retriggers; a new frame needs a low-then-high transition.
- Reset, including mid-frame or mid-handshake, returns to COLLECT immediately and drives:
  - `result_valid = 0`, `busy = 0`, `digit = 0`, `max_score = 0`, `count_err = 0`.
  - All internal registers cleared.
- Arithmetic: signed compare only; no accumulation, so no overflow is possible.

## Timing
- Score capture: a score presented on edge N is reflected in `run_max`/`run_idx` after edge N.
- Result latency, with `check_max` first sampled high on edge T (`chk_q` low):
  - EVAL is active after edge T.
  - `result_valid` rises after edge T+1.
- Handshake: the transfer occurs on the edge where `result_valid & result_ready`. `result_valid` falls after that edge.
  - If `result_ready` is already high, `result_valid` is high for exactly one cycle.
- Throughput: the earliest the next frame's first score can be accepted is the cycle after the handshake edge.
- `busy` is registered from the state and is high from the cycle after edge T through the handshake edge.

## Test plan
- In-order frame: scores idx 0..9 = {-5,3,17,2,-100,9,16,0,1,4}, then `check_max` pulse, `result_ready` held 1 -> `digit = 2`, `max_score = 17`, `count_err = 0`, `result_valid` high for one cycle, 2 edges after `check_max` is sampled.
- Tie plus all-negative: all ten scores = -7 -> `digit = 0`, `max_score = -7`, `count_err = 0`.
- Malformed frame: idx 5 sent twice, idx 11 sent, idx 9 missing, max at idx 3 = 40 -> `digit = 3`, `max_score = 40`, `count_err = 1`.
- Backpressure: `result_ready = 0` for 6 cycles while `valid_digit` pulses with idx 0 / score 999, and `check_max` stays high -> outputs stable, `result_valid` held. On ready: one transfer, no retrigger. The next frame is unaffected by 999.
- Same-cycle event: the last score (idx 9 = 50, the maximum) arrives in the `check_max` rising cycle -> `digit = 9`, `max_score = 50`.
- Reset mid-RESULT: assert `rst` while `result_valid = 1` -> all outputs 0 asynchronously. A following clean frame classifies correctly.

Source files
------------

// File: rtl/digit_argmax_if.sv
// Score stream from the inference sequencer plus the result handshake toward
// the display/UART side. The master drives scores and ready; the slave is the argmax unit.
`timescale 1ns/1ps

interface digit_argmax_if #(
  parameter int SCORE_W = 24
);
  logic                      valid_digit;
  logic [3:0]                score_idx;
  logic signed [SCORE_W-1:0] score;
  logic                      check_max;
  logic                      result_ready;
  logic                      result_valid;
  logic [3:0]                digit;
  logic signed [SCORE_W-1:0] max_score;
  logic                      count_err;
  logic                      busy;

  modport master (
    output valid_digit, score_idx, score, check_max, result_ready,
    input  result_valid, digit, max_score, count_err, busy
  );

  modport slave (
    input  valid_digit, score_idx, score, check_max, result_ready,
    output result_valid, digit, max_score, count_err, busy
  );
endinterface

// File: rtl/digit_argmax.sv
// Running-maximum classifier over the layer-2 class scores; reports the winning
// digit, its score and a frame-malformed flag when check_max rises.
`timescale 1ns/1ps

module digit_argmax #(
  parameter int SCORE_W     = 24,
  parameter int NUM_CLASSES = 10
) (
  input  logic           clk,
  input  logic           rst,
  digit_argmax_if.slave  bus
);

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    RESULT
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t                    state;
  state_t                    next_state;
  logic signed [SCORE_W-1:0] run_max;
  logic [3:0]                run_idx;
  logic [NUM_CLASSES-1:0]    seen;
  logic                      any_seen;
  logic                      bad;
  logic                      chk_q;
  logic                      busy_q;
  logic [3:0]                digit_q;
  logic signed [SCORE_W-1:0] max_score_q;
  logic                      count_err_q;

  logic                      check_rise;
  logic                      idx_legal;
  logic [NUM_CLASSES-1:0]    idx_onehot;
  logic                      dup;
  logic                      collecting;
  logic                      capture;
  logic                      reject;
  logic                      accept;

  assign check_rise = bus.check_max & ~chk_q;
  assign idx_legal  = (bus.score_idx <= LAST_IDX);
  // Out-of-range indices shift the bit off the top, so dup is simply 0 for them.
  assign idx_onehot = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << bus.score_idx;
  assign dup        = |(seen & idx_onehot);
  assign collecting = (state == COLLECT);
  assign capture    = collecting & bus.valid_digit & idx_legal & ~dup;
  assign reject     = collecting & bus.valid_digit & (~idx_legal | dup);
  assign accept     = (state == RESULT) & bus.result_ready;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      COLLECT: if (check_rise)       next_state = EVAL;
      EVAL:                          next_state = RESULT;
      RESULT:  if (bus.result_ready) next_state = COLLECT;
      default:                       next_state = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= COLLECT;
      chk_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      chk_q  <= bus.check_max;
      busy_q <= (next_state != COLLECT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max     <= '0;
      run_idx     <= '0;
      seen        <= '0;
      any_seen    <= 1'b0;
      bad         <= 1'b0;
      digit_q     <= '0;
      max_score_q <= '0;
      count_err_q <= 1'b0;
    end else begin
      if (capture) begin
        seen     <= seen | idx_onehot;
        any_seen <= 1'b1;
        // Strict compare: on a tie the earlier score keeps the lead.
        if (!any_seen || (bus.score > run_max)) begin
          run_max <= bus.score;
          run_idx <= bus.score_idx;
        end
      end
      if (reject) bad <= 1'b1;

      if (state == EVAL) begin
        digit_q     <= run_idx;
        max_score_q <= run_max;
        count_err_q <= bad | (seen != {NUM_CLASSES{1'b1}});
      end

      if (accept) begin
        run_max  <= '0;
        run_idx  <= '0;
        seen     <= '0;
        any_seen <= 1'b0;
        bad      <= 1'b0;
      end
    end
  end

  assign bus.result_valid = (state == RESULT);
  assign bus.busy         = busy_q;
  assign bus.digit        = digit_q;
  assign bus.max_score    = max_score_q;
  assign bus.count_err    = count_err_q;

endmodule
